core_lsu_ctrl: RTL

Parametrised load/store sequencer between execute and the data-memory bus. On an issue pulse it computes the effective address and byte strobes, then drives one or two valid/ready bus beats. Misaligned accesses are either split across two aligned beats or trapped, depending on a parameter. Load data is merged, lane-shifted and sign/zero-extended into an XLEN result.

---
 rtl/core_lsu_ctrl_pkg.sv | 51 +++++
 rtl/core_lsu_align.sv | 73 +++++++
 rtl/core_lsu_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/core_lsu_ctrl_pkg.sv
// ============================================================================
// Module  : core_lsu_ctrl_pkg
// Brief   : Opcodes, FUNCT3 codes, LSU state encodings and decode helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package core_lsu_ctrl_pkg;

  localparam logic [6:0] OPCODE_I_LOAD = 7'b0000011;
  localparam logic [6:0] OPCODE_S      = 7'b0100011;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LD  = 3'b011;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_LWU = 3'b110;
  localparam logic [2:0] FUNCT3_SD  = 3'b011;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic EXT_SIGNED   = 1'b0;
  localparam logic EXT_UNSIGNED = 1'b1;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t LSU_IDLE = 3'd0;
  localparam lsu_state_t LSU_REQ0 = 3'd1;
  localparam lsu_state_t LSU_RSP0 = 3'd2;
  localparam lsu_state_t LSU_REQ1 = 3'd3;
  localparam lsu_state_t LSU_RSP1 = 3'd4;

  // Doubleword accesses and LWU only exist on a 64-bit datapath.
  function automatic logic f3_illegal(input logic [2:0] f3,
                                      input logic       is_store,
                                      input logic       xlen64);
    logic ill;
    ill = (f3 == 3'b111);
    if (is_store && f3[2]) ill = 1'b1;
    if (!xlen64 && ((f3 == FUNCT3_LD) || (f3 == FUNCT3_LWU))) ill = 1'b1;
    return ill;
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_lsu_align.sv
// ============================================================================
// Module  : core_lsu_align
// Brief   : Byte strobes, store lane shifting, load merge and extension.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module core_lsu_align
  import core_lsu_ctrl_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SW   = XLEN / 8,
  localparam int OW   = $clog2(SW)
) (
  input  logic [OW-1:0]   off_i,
  input  logic [2:0]      f3_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [XLEN-1:0] low_i,
  input  logic            beat1_i,
  output logic [SW-1:0]   strb0_o,
  output logic [SW-1:0]   strb1_o,
  output logic [XLEN-1:0] wdata0_o,
  output logic [XLEN-1:0] wdata1_o,
  output logic [XLEN-1:0] merged_o,
  output logic [XLEN-1:0] ext_o
);

  logic [SW-1:0]   size_mask;
  logic [XLEN-1:0] data_mask;
  logic [OW+2:0]   sh;
  logic [OW+3:0]   rsh;
  logic [OW:0]     rsw;
  logic            sign;

  always_comb begin
    size_mask = '0;
    for (int i = 0; i < SW; i++) begin
      if (i < (1 << f3_i[1:0])) size_mask[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < SW; g++) begin : g_byte_mask
    assign data_mask[8*g +: 8] = {8{size_mask[g]}};
  end

  // Beat 1 carries whatever spilled past the top lane of beat 0.
  assign sh  = {off_i, 3'b000};
  assign rsh = (OW + 4)'(XLEN) - {1'b0, sh};
  assign rsw = (OW + 1)'(SW) - {1'b0, off_i};

  assign strb0_o  = size_mask << off_i;
  assign strb1_o  = size_mask >> rsw;
  assign wdata0_o = data_i << sh;
  assign wdata1_o = data_i >> rsh;

  assign merged_o = beat1_i ? (low_i | ((rdata_i << rsh) & data_mask))
                            : (rdata_i >> sh);

  always_comb begin
    case (f3_i[1:0])
      SIZE_B:  sign = merged_o[7];
      SIZE_H:  sign = merged_o[15];
      SIZE_W:  sign = merged_o[31];
      default: sign = merged_o[XLEN-1];
    endcase
    ext_o = (merged_o & data_mask) |
            ((sign && (f3_i[2] == EXT_SIGNED)) ? ~data_mask : '0);
  end

endmodule

`default_nettype wire

// File: rtl/core_lsu_ctrl.sv
// ============================================================================
// Module  : core_lsu_ctrl
// Brief   : Load/store sequencer issuing one or two aligned bus beats.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module core_lsu_ctrl
  import core_lsu_ctrl_pkg::*;
#(
  parameter  int XLEN             = 32,
  parameter  int ABITS            = 32,
  parameter  int SPLIT_MISALIGNED = 1,
  localparam int SW               = XLEN / 8,
  localparam int OW               = $clog2(SW)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             C_CMEM,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNCT3,
  input  logic [XLEN-1:0]  IMM,
  input  logic [XLEN-1:0]  REG_RDATA1,
  input  logic [XLEN-1:0]  REG_RDATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic             MISALIGN,
  output logic             ILLEGAL,
  output logic [XLEN-1:0]  LOAD_DATA,
  output logic             DMEM_VALID,
  input  logic             DMEM_READY,
  output logic             DMEM_WE,
  output logic [ABITS-1:0] DMEM_ADDR,
  output logic [XLEN-1:0]  DMEM_WDATA,
  output logic [SW-1:0]    DMEM_STRB,
  input  logic             DMEM_RVALID,
  input  logic [XLEN-1:0]  DMEM_RDATA
);

  lsu_state_t       state_q, state_d;
  logic [ABITS-1:0] ea_q;
  logic [2:0]       f3_q;
  logic [XLEN-1:0]  data_q, low_q, load_data_q;
  logic             we_q, done_q, mis_q, ill_q;
  logic             done_d, mis_d, ill_d, complete;

  logic [ABITS-1:0] ea_in;
  logic [3:0]       size_in, size_q;
  logic             is_ld_in, is_st_in, ill_in, mis_in, trap_in, go_in;
  logic [OW-1:0]    off_q;
  logic [ABITS-1:0] base_q;
  logic             cross_q, beat1;

  logic [SW-1:0]    strb0, strb1;
  logic [XLEN-1:0]  wdata0, wdata1, merged, ext;

  assign ea_in    = ABITS'(REG_RDATA1 + IMM);
  assign size_in  = 4'd1 << FUNCT3[1:0];
  assign mis_in   = ((4'(ea_in[OW-1:0])) & (size_in - 4'd1)) != 4'd0;
  assign is_ld_in = (OPCODE == OPCODE_I_LOAD);
  assign is_st_in = (OPCODE == OPCODE_S);
  assign ill_in   = f3_illegal(FUNCT3, is_st_in, XLEN == 64);
  assign trap_in  = (SPLIT_MISALIGNED == 0) && mis_in;
  assign go_in    = (is_ld_in || is_st_in) && !ill_in && !trap_in;

  assign off_q   = ea_q[OW-1:0];
  assign size_q  = 4'd1 << f3_q[1:0];
  assign base_q  = {ea_q[ABITS-1:OW], {OW{1'b0}}};
  assign cross_q = (4'(off_q) + size_q) > 4'(SW);
  assign beat1   = (state_q == LSU_REQ1) || (state_q == LSU_RSP1);

  core_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .off_i   (off_q),
    .f3_i    (f3_q),
    .data_i  (data_q),
    .rdata_i (DMEM_RDATA),
    .low_i   (low_q),
    .beat1_i (beat1),
    .strb0_o (strb0),
    .strb1_o (strb1),
    .wdata0_o(wdata0),
    .wdata1_o(wdata1),
    .merged_o(merged),
    .ext_o   (ext)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= LSU_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      LSU_IDLE: if (C_CMEM && go_in) state_d = LSU_REQ0;
      LSU_REQ0: begin
        if (DMEM_READY) begin
          if (!we_q) begin
            state_d = LSU_RSP0;
          end else if (cross_q) begin
            state_d = LSU_REQ1;
          end else begin
            state_d  = LSU_IDLE;
            complete = 1'b1;
          end
        end
      end
      LSU_RSP0: begin
        if (DMEM_RVALID) begin
          state_d  = cross_q ? LSU_REQ1 : LSU_IDLE;
          complete = !cross_q;
        end
      end
      LSU_REQ1: begin
        if (DMEM_READY) begin
          state_d  = we_q ? LSU_IDLE : LSU_RSP1;
          complete = we_q;
        end
      end
      LSU_RSP1: begin
        if (DMEM_RVALID) begin
          state_d  = LSU_IDLE;
          complete = 1'b1;
        end
      end
      default: state_d = LSU_IDLE;
    endcase

    // Rejected issues finish without touching the bus.
    done_d = complete;
    mis_d  = 1'b0;
    ill_d  = 1'b0;
    if ((state_q == LSU_IDLE) && C_CMEM && !go_in) begin
      done_d = 1'b1;
      ill_d  = (is_ld_in || is_st_in) && ill_in;
      mis_d  = (is_ld_in || is_st_in) && !ill_in && trap_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ea_q        <= '0;
      f3_q        <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      low_q       <= '0;
      load_data_q <= '0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      if ((state_q == LSU_IDLE) && C_CMEM) begin
        ea_q   <= ea_in;
        f3_q   <= FUNCT3;
        data_q <= REG_RDATA2;
        we_q   <= is_st_in;
      end
      if ((state_q == LSU_RSP0) && DMEM_RVALID) low_q <= merged;
      if (complete && !we_q) load_data_q <= ext;
      done_q <= done_d;
      mis_q  <= mis_d;
      ill_q  <= ill_d;
    end
  end

  always_comb begin
    BUSY       = (state_q != LSU_IDLE);
    DMEM_VALID = 1'b0;
    DMEM_WE    = 1'b0;
    DMEM_ADDR  = '0;
    DMEM_STRB  = '0;
    DMEM_WDATA = '0;
    case (state_q)
      LSU_REQ0: begin
        DMEM_VALID = 1'b1;
        DMEM_WE    = we_q;
        DMEM_ADDR  = base_q;
        DMEM_STRB  = strb0;
        DMEM_WDATA = wdata0;
      end
      LSU_REQ1: begin
        DMEM_VALID = 1'b1;
        DMEM_WE    = we_q;
        DMEM_ADDR  = base_q + ABITS'(SW);
        DMEM_STRB  = strb1;
        DMEM_WDATA = wdata1;
      end
      default: ;
    endcase
  end

  assign DONE      = done_q;
  assign MISALIGN  = mis_q;
  assign ILLEGAL   = ill_q;
  assign LOAD_DATA = load_data_q;

endmodule

`default_nettype wire
